bram_port_arbiter: RTL and testbench
====================================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports are named clock and reset.
REQ-002 SHALL take parameter ADDR_W, default 32: BRAM word-address width.
REQ-003 SHALL take parameter STARVE_LIMIT, default 15: maximum consecutive denied cycles before the feeder is forced a grant.
REQ-004 SHALL take parameter WE_MASK, default 16'h00ff: byte-enable pattern driven on writes.
REQ-005 Ports SHALL be:
- clock  in  1  system clock
- reset  in  1  async active-low reset
- c_req  in  1  cache-refill burst request
- c_addr  in  ADDR_W  burst start word address
- c_len  in  8  burst beat count
- c_gnt  out  1  burst accepted
- c_rvalid  out  1  refill read data valid on BRAM read_out
- c_done  out  1  last refill beat valid
- w_req  in  1  outlier write-back request
- w_addr  in  ADDR_W  write word address
- w_wdata  in  128  write data
- w_gnt  out  1  write accepted
- f_req  in  1  feeder read request
- f_addr  in  ADDR_W  feeder word address
- f_gnt  out  1  feeder read accepted
- f_rvalid  out  1  feeder read data valid
- bram_addr  out  ADDR_W  shared address, fanned to x/y/z BRAMs
- bram_en  out  1  shared enable
- bram_we  out  16  shared byte write enable
- bram_wdata  out  128  shared write data
- busy  out  1  burst active or reads in flight

Function
REQ-006 Handshake SHALL be req/gnt: a transfer occurs at a rising edge where x_req and x_gnt are both 1. Gnt is combinational from state and reqs. Requesters hold addr/data stable while req=1 and gnt=0.
REQ-007 In IDLE, at most one gnt SHALL be high per cycle. Priority is c > w > f, except that f wins when f_req=1 and starve_cnt==STARVE_LIMIT.
REQ-008 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on every cycle f_req=1 without an f transfer. It clears on an f transfer or when f_req=0.
REQ-009 A transfer at edge E SHALL drive bram_en=1, bram_addr and bram_we registered for exactly the cycle after E. bram_we=WE_MASK and bram_wdata=w_wdata for w; bram_we=0 for c/f.
REQ-010 Read response SHALL assert c_rvalid/f_rvalid one cycle after the corresponding bram_en cycle, i.e. 2 cycles after the handshake edge. The BRAM latency is 1.
REQ-011 A c transfer SHALL move the FSM IDLE->CBURST and issue L=max(c_len,1) consecutive reads at c_addr, c_addr+1, ..., one per cycle. Address addition wraps modulo 2^ADDR_W.
REQ-012 In CBURST all gnts SHALL be 0; bursts are never preempted, including by forced feeder grants. The FSM returns to IDLE in the cycle after the last beat is issued.
REQ-013 c_done SHALL pulse together with the c_rvalid of beat L. For L=1, c_rvalid and c_done coincide.
REQ-014 Back-to-back transfers in consecutive cycles SHALL be supported, giving one BRAM access per cycle with no bubble.
REQ-015 When no transfer occurs, bram_en=0 and bram_we=0; bram_addr and bram_wdata hold their last value.
REQ-016 busy SHALL be 1 while state==CBURST or any rvalid is pending.

Reset
REQ-017 While reset=0, all outputs SHALL be 0, state=IDLE and starve_cnt=0.
REQ-018 Reset asserted mid-burst or with reads in flight SHALL abort silently: no c_done or rvalid pulse is emitted after reset release.
REQ-019 Gnts SHALL stay 0 in the first cycle after reset release.

Structure
REQ-020 Package bram_arb_pkg SHALL hold the state enum {IDLE, CBURST}, the requester-id encoding {REQ_C, REQ_W, REQ_F, REQ_NONE}, and the WE_MASK/STARVE_LIMIT defaults.
REQ-021 Sub-module bram_rd_pipe SHALL hold the 2-stage valid/requester-id/last pipeline that generates rvalid/c_done. All other logic stays in the top.

Verification
REQ-022 Single f read: f_req=1, f_addr=0x10 -> f_gnt same cycle; bram_en=1 with addr 0x10 next cycle; f_rvalid=1 one cycle later; bram_we=0.
REQ-023 Burst: c_addr=0x20, c_len=4 -> 4 bram_en cycles with addr 0x20..0x23; 4 c_rvalid; c_done on the 4th; w_gnt=f_gnt=0 throughout, even with w_req/f_req=1.
REQ-024 Write: w_addr=0x7, w_wdata=0 -> bram_we=16'h00ff, bram_wdata=0, addr 0x7 for one cycle; no rvalid.
REQ-025 Starvation: w_req held high, f_req high -> w granted 15 cycles, f granted on the 16th, then w resumes.
REQ-026 Simultaneous c/w/f request in IDLE -> c_gnt only. Boundary cases: c_len=0 gives 1 beat; c_addr=0xFFFFFFFF, c_len=2 gives addrs 0xFFFFFFFF, 0x0.
REQ-027 Reset during beat 2 of a 4-beat burst -> all outputs 0, no c_done after release, state IDLE.

Source files
------------

// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and defaults for the three-requester BRAM port arbiter.
package bram_arb_pkg;

  localparam int          STARVE_LIMIT_DEF = 15;
  localparam logic [15:0] WE_MASK_DEF      = 16'h00ff;

  typedef enum logic {
    IDLE,
    CBURST
  } state_e;

  typedef enum logic [1:0] {
    REQ_C,
    REQ_W,
    REQ_F,
    REQ_NONE
  } req_id_e;

  // Tag carried alongside each BRAM read until its data is valid.
  typedef struct packed {
    logic    valid;
    req_id_e id;
    logic    last;
  } rd_tag_t;

  localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, id: REQ_NONE, last: 1'b0};

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester handshakes plus the shared BRAM port, seen from the arbiter (slave)
// and from the requesters/BRAM side (master).
interface bram_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              c_req;
  logic [ADDR_W-1:0] c_addr;
  logic [7:0]        c_len;
  logic              c_gnt;
  logic              c_rvalid;
  logic              c_done;

  logic              w_req;
  logic [ADDR_W-1:0] w_addr;
  logic [127:0]      w_wdata;
  logic              w_gnt;

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;

  logic [ADDR_W-1:0] bram_addr;
  logic              bram_en;
  logic [15:0]       bram_we;
  logic [127:0]      bram_wdata;
  logic              busy;

  modport slave (
    input  c_req, c_addr, c_len, w_req, w_addr, w_wdata, f_req, f_addr,
    output c_gnt, c_rvalid, c_done, w_gnt, f_gnt, f_rvalid,
           bram_addr, bram_en, bram_we, bram_wdata, busy
  );

  modport master (
    output c_req, c_addr, c_len, w_req, w_addr, w_wdata, f_req, f_addr,
    input  c_gnt, c_rvalid, c_done, w_gnt, f_gnt, f_rvalid,
           bram_addr, bram_en, bram_we, bram_wdata, busy
  );
endinterface

// File: rtl/bram_port_arbiter_rd_pipe.sv
// Two-stage read tag pipeline: stage 1 aligns with the BRAM enable cycle,
// stage 2 with the data returned one cycle later.
module bram_rd_pipe
  import bram_arb_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  rd_tag_t issue_i,
  output logic    c_rvalid_o,
  output logic    c_done_o,
  output logic    f_rvalid_o,
  output logic    pending_o
);

  rd_tag_t s1_q, s2_q;

  // NOTE: non-blocking assignments let s2_q take the old s1_q on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q <= RD_TAG_IDLE;
      s2_q <= RD_TAG_IDLE;
    end else begin
      s1_q <= issue_i;
      s2_q <= s1_q;
    end
  end

  assign c_rvalid_o = s2_q.valid && (s2_q.id == REQ_C);
  assign c_done_o   = c_rvalid_o && s2_q.last;
  assign f_rvalid_o = s2_q.valid && (s2_q.id == REQ_F);
  assign pending_o  = s1_q.valid || s2_q.valid;

endmodule

// File: rtl/bram_port_arbiter.sv
// Arbitrates cache-refill bursts, write-backs and feeder reads onto one shared
// BRAM port, with a starvation override for the feeder.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int          ADDR_W       = 32,
  parameter int          STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter logic [15:0] WE_MASK      = WE_MASK_DEF
) (
  input logic               clock,
  input logic               reset,
  bram_port_arbiter_if.slave bus
);

  localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [7:0]        beats_q, beats_d;    // burst beats still to be issued
  logic              init_q;              // blocks grants in the first cycle out of reset
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q, en_d;
  logic [15:0]       we_q, we_d;
  logic [127:0]      wdata_q, wdata_d;
  req_id_e           sel;
  rd_tag_t           issue;
  logic              pending;

  // NOTE: every signal gets its default first so no path can infer a latch.
  always_comb begin
    sel      = REQ_NONE;
    state_d  = state_q;
    beats_d  = beats_q;
    addr_d   = addr_q;
    en_d     = 1'b0;
    we_d     = '0;
    wdata_d  = wdata_q;
    issue    = RD_TAG_IDLE;
    starve_d = '0;

    if (state_q == IDLE && init_q) begin
      if (bus.f_req && starve_q == STARVE_MAX) sel = REQ_F;
      else if (bus.c_req)                      sel = REQ_C;
      else if (bus.w_req)                      sel = REQ_W;
      else if (bus.f_req)                      sel = REQ_F;
    end

    case (sel)
      REQ_C: begin
        state_d = CBURST;
        addr_d  = bus.c_addr;
        en_d    = 1'b1;
        beats_d = (bus.c_len == 8'd0) ? 8'd0 : bus.c_len - 8'd1;
        issue   = '{valid: 1'b1, id: REQ_C, last: (bus.c_len <= 8'd1)};
      end
      REQ_W: begin
        addr_d  = bus.w_addr;
        en_d    = 1'b1;
        we_d    = WE_MASK;
        wdata_d = bus.w_wdata;
      end
      REQ_F: begin
        addr_d = bus.f_addr;
        en_d   = 1'b1;
        issue  = '{valid: 1'b1, id: REQ_F, last: 1'b0};
      end
      default: ;
    endcase

    // The burst keeps the port until its last beat has had its BRAM cycle.
    if (state_q == CBURST) begin
      if (beats_q != 8'd0) begin
        addr_d  = addr_q + ADDR_W'(1);
        en_d    = 1'b1;
        beats_d = beats_q - 8'd1;
        issue   = '{valid: 1'b1, id: REQ_C, last: (beats_q == 8'd1)};
      end else begin
        state_d = IDLE;
      end
    end

    if (bus.f_req && sel != REQ_F) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SC_W'(1);
    end
  end

  // NOTE: the data registers are reset too, since every output must read 0 in reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      beats_q  <= '0;
      init_q   <= 1'b0;
      addr_q   <= '0;
      en_q     <= 1'b0;
      we_q     <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      beats_q  <= beats_d;
      init_q   <= 1'b1;
      addr_q   <= addr_d;
      en_q     <= en_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
    end
  end

  bram_rd_pipe u_rd_pipe (
    .clock      (clock),
    .reset      (reset),
    .issue_i    (issue),
    .c_rvalid_o (bus.c_rvalid),
    .c_done_o   (bus.c_done),
    .f_rvalid_o (bus.f_rvalid),
    .pending_o  (pending)
  );

  assign bus.c_gnt      = (sel == REQ_C);
  assign bus.w_gnt      = (sel == REQ_W);
  assign bus.f_gnt      = (sel == REQ_F);
  assign bus.bram_addr  = addr_q;
  assign bus.bram_en    = en_q;
  assign bus.bram_we    = we_q;
  assign bus.bram_wdata = wdata_q;
  assign bus.busy       = (state_q == CBURST) || pending;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: inputs change and outputs are sampled
// on the falling clock edge, expectations are hand-computed.
module tb_bram_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [127:0] WDATA_A = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  bram_port_arbiter_if #(.ADDR_W(32)) bus ();

  bram_port_arbiter #(
    .ADDR_W       (32),
    .STARVE_LIMIT (15),
    .WE_MASK      (16'h00ff)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_reqs();
    bus.c_req = 1'b0;
    bus.w_req = 1'b0;
    bus.f_req = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, 128'({bus.c_gnt, bus.w_gnt, bus.f_gnt, bus.c_rvalid,
                               bus.c_done, bus.f_rvalid, bus.bram_en, bus.busy}), 128'(8'h00));
    check({tag, "_we"}, 128'(bus.bram_we), 128'(16'h0000));
  endtask

  initial begin
    bus.c_req = 1'b0; bus.c_addr = '0; bus.c_len = '0;
    bus.w_req = 1'b0; bus.w_addr = '0; bus.w_wdata = '0;
    bus.f_req = 1'b0; bus.f_addr = '0;

    // Reset state, with every requester asking
    repeat (2) @(negedge clock);
    bus.c_req = 1'b1; bus.w_req = 1'b1; bus.f_req = 1'b1;
    #1;
    check_quiet("rst");
    check("rst_addr", 128'(bus.bram_addr), 128'(32'h0));
    check("rst_wdata", bus.bram_wdata, 128'h0);
    idle_reqs();

    // Release reset; no grant in the first cycle, then a single feeder read
    @(negedge clock);
    reset = 1'b1;
    bus.f_req = 1'b1; bus.f_addr = 32'h10;
    #1;
    check("gnt_first_cycle", 128'({bus.c_gnt, bus.w_gnt, bus.f_gnt}), 128'(3'b000));
    step();
    #1;
    check("f_gnt", 128'({bus.c_gnt, bus.w_gnt, bus.f_gnt}), 128'(3'b001));
    step();
    bus.f_req = 1'b0;
    check("f_en", 128'(bus.bram_en), 128'(1'b1));
    check("f_addr", 128'(bus.bram_addr), 128'(32'h10));
    check("f_we", 128'(bus.bram_we), 128'(16'h0));
    check("f_rvalid_early", 128'(bus.f_rvalid), 128'(1'b0));
    check("f_busy", 128'(bus.busy), 128'(1'b1));
    step();
    check("f_rvalid", 128'({bus.f_rvalid, bus.bram_en}), 128'(2'b10));
    step();
    check("f_rvalid_end", 128'(bus.f_rvalid), 128'(1'b0));

    // Two back-to-back writes
    bus.w_req = 1'b1; bus.w_addr = 32'h5; bus.w_wdata = WDATA_A;
    #1;
    check("w_gnt_a", 128'(bus.w_gnt), 128'(1'b1));
    step();
    check("wa_bus", 128'({bus.bram_en, bus.bram_we, bus.bram_addr}), 128'({1'b1, 16'h00ff, 32'h5}));
    check("wa_wdata", bus.bram_wdata, WDATA_A);
    bus.w_addr = 32'h7; bus.w_wdata = '0;
    #1;
    check("w_gnt_b2b", 128'(bus.w_gnt), 128'(1'b1));
    step();
    bus.w_req = 1'b0;
    check("wb_bus", 128'({bus.bram_en, bus.bram_we, bus.bram_addr}), 128'({1'b1, 16'h00ff, 32'h7}));
    check("wb_wdata", bus.bram_wdata, 128'h0);
    step();
    check("w_after", 128'({bus.bram_en, bus.bram_we, bus.bram_addr}), 128'({1'b0, 16'h0, 32'h7}));
    check("w_no_rvalid", 128'({bus.c_rvalid, bus.f_rvalid}), 128'(2'b00));

    // Simultaneous requests, then a 4-beat burst that w/f cannot preempt
    bus.c_req = 1'b1; bus.c_addr = 32'h20; bus.c_len = 8'd4;
    bus.w_req = 1'b1; bus.w_addr = 32'h300;
    bus.f_req = 1'b1; bus.f_addr = 32'h400;
    #1;
    check("sim_gnt", 128'({bus.c_gnt, bus.w_gnt, bus.f_gnt}), 128'(3'b100));
    step();
    bus.c_req = 1'b0;
    for (int b = 0; b < 4; b++) begin
      #1;
      check("burst_bus", 128'({bus.bram_en, bus.bram_we, bus.bram_addr}),
            128'({1'b1, 16'h0, 32'h20 + 32'(b)}));
      check("burst_gnts", 128'({bus.c_gnt, bus.w_gnt, bus.f_gnt}), 128'(3'b000));
      check("burst_rv", 128'({bus.c_rvalid, bus.c_done, bus.busy}), 128'({(b > 0), 1'b0, 1'b1}));
      step();
    end
    check("burst_done", 128'({bus.bram_en, bus.c_rvalid, bus.c_done}), 128'(3'b011));
    idle_reqs();
    step();
    check("burst_end", 128'({bus.c_rvalid, bus.c_done, bus.busy}), 128'(3'b000));

    // Starvation: w wins 15 times, the feeder is forced on the 16th
    bus.w_req = 1'b1; bus.w_addr = 32'h100;
    bus.f_req = 1'b1; bus.f_addr = 32'h200;
    for (int i = 0; i < 15; i++) begin
      #1;
      check("starve_w", 128'({bus.w_gnt, bus.f_gnt}), 128'(2'b10));
      step();
    end
    #1;
    check("starve_f", 128'({bus.w_gnt, bus.f_gnt}), 128'(2'b01));
    step();
    #1;
    check("resume_w", 128'({bus.w_gnt, bus.f_gnt}), 128'(2'b10));
    check("forced_f_bus", 128'({bus.bram_en, bus.bram_we, bus.bram_addr}), 128'({1'b1, 16'h0, 32'h200}));
    idle_reqs();
    step();
    check("forced_f_rvalid", 128'(bus.f_rvalid), 128'(1'b1));
    step();

    // c_len = 0 behaves as a single beat
    bus.c_req = 1'b1; bus.c_addr = 32'h40; bus.c_len = 8'd0;
    #1;
    check("len0_gnt", 128'(bus.c_gnt), 128'(1'b1));
    step();
    bus.c_req = 1'b0;
    check("len0_bus", 128'({bus.bram_en, bus.bram_addr}), 128'({1'b1, 32'h40}));
    step();
    check("len0_done", 128'({bus.bram_en, bus.c_rvalid, bus.c_done}), 128'(3'b011));
    step();
    check("len0_end", 128'({bus.c_rvalid, bus.c_done}), 128'(2'b00));

    // Address wrap at the top of the space
    bus.c_req = 1'b1; bus.c_addr = 32'hffff_ffff; bus.c_len = 8'd2;
    #1;
    step();
    bus.c_req = 1'b0;
    check("wrap_beat1", 128'({bus.bram_en, bus.bram_addr}), 128'({1'b1, 32'hffff_ffff}));
    step();
    check("wrap_beat2", 128'({bus.bram_en, bus.bram_addr}), 128'({1'b1, 32'h0}));
    check("wrap_rv1", 128'({bus.c_rvalid, bus.c_done}), 128'(2'b10));
    step();
    check("wrap_done", 128'({bus.bram_en, bus.c_rvalid, bus.c_done}), 128'(3'b011));
    step();

    // Reset during beat 2 of a 4-beat burst aborts silently
    bus.c_req = 1'b1; bus.c_addr = 32'h80; bus.c_len = 8'd4;
    #1;
    step();
    bus.c_req = 1'b0;
    check("abort_beat1", 128'(bus.bram_addr), 128'(32'h80));
    step();
    check("abort_beat2", 128'({bus.bram_addr, bus.c_rvalid}), 128'({32'h81, 1'b1}));
    reset = 1'b0;
    #1;
    check_quiet("abort_rst");
    check("abort_addr", 128'(bus.bram_addr), 128'(32'h0));
    step();
    reset = 1'b1;
    bus.w_req = 1'b1; bus.w_addr = 32'h9;
    #1;
    check("abort_gnt_first", 128'(bus.w_gnt), 128'(1'b0));
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      check("abort_no_rv", 128'({bus.c_rvalid, bus.c_done, bus.f_rvalid}), 128'(3'b000));
      check("abort_idle_w", 128'(bus.w_gnt), 128'(1'b1));
    end
    idle_reqs();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
